// File: rtl/bcd_timer_ctrl_if.sv
// Button, zero-flag and counter-control signals between the countdown
// sequencer and its surroundings (buttons, digit counters, display).
interface bcd_timer_ctrl_if #(
  parameter int DIGITS = 4
) ();
  logic              start;    // start / pause / resume / acknowledge pulse
  logic              mode;     // enter set mode / advance selected digit pulse
  logic              adj;      // decrement selected digit pulse
  logic              clear;    // clear all digits pulse
  logic [DIGITS-1:0] digz;     // per-digit "counter reads 0" flags
  logic [DIGITS-1:0] en;       // per-digit count enables
  logic              cnt_clr;  // clear to all digit counters
  logic [1:0]        sel;      // selected digit in set mode
  logic              running;  // timer is counting down
  logic              alarm;    // alarm is sounding

  // Environment side: drives buttons and zero flags, observes the sequencer.
  modport master (
    output start, mode, adj, clear, digz,
    input  en, cnt_clr, sel, running, alarm
  );

  // Sequencer side.
  modport slave (
    input  start, mode, adj, clear, digz,
    output en, cnt_clr, sel, running, alarm
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Countdown timer sequencer for a chain of external cascaded BCD down-counter
// digits. Generates timebase and manual-set count enables, detects the
// all-zero condition and runs the idle/set/run/pause/alarm state machine.
module bcd_timer_ctrl #(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 1000,
  parameter int ALARM_TICKS = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  bcd_timer_ctrl_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  localparam logic [PW-1:0] P_LAST   = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] A_LAST   = AW'(ALARM_TICKS - 1);
  localparam logic [1:0]    SEL_LAST = 2'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [AW-1:0]     a_q, a_d;
  logic [1:0]        sel_q, sel_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              running_q, alarm_q;

  logic [DIGITS-1:0] tick_en;
  logic              all_zero;
  logic              p_wrap;

  assign all_zero = &bus.digz;
  assign p_wrap   = (p_q == P_LAST);

  // Borrow cascade for a timebase tick: a digit decrements when every
  // lower digit currently reads 0 (it is about to wrap to 9).
  always_comb begin
    tick_en    = '0;
    tick_en[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      tick_en[i] = tick_en[i-1] & bus.digz[i-1];
    end
  end

  // Next-state, prescaler, alarm counter and enable decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    p_d       = p_q;
    a_d       = a_q;
    sel_d     = sel_q;
    en_d      = '0;
    cnt_clr_d = 1'b0;

    if (bus.clear) begin
      state_d   = S_IDLE;
      p_d       = '0;
      a_d       = '0;
      sel_d     = '0;
      cnt_clr_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // A start on an all-zero display is swallowed.
            if (!all_zero) begin
              state_d = S_RUN;
              p_d     = '0;
            end
          end else if (bus.mode) begin
            state_d = S_SET;
            sel_d   = '0;
          end
        end

        S_SET: begin
          if (bus.start) begin
            // Start has no meaning while setting; it still masks mode/adj.
          end else if (bus.mode) begin
            if (sel_q == SEL_LAST) begin
              state_d = S_IDLE;
              sel_d   = '0;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end else if (bus.adj) begin
            // Manual decrement touches only the selected digit, no cascade.
            for (int i = 0; i < DIGITS; i++) begin
              if (sel_q == 2'(i)) en_d[i] = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.start) begin
            state_d = S_PAUSE;
          end else if (all_zero && (en_q == '0)) begin
            // Only trust the zero flags when no decrement is in flight.
            state_d = S_ALARM;
            a_d     = '0;
            p_d     = '0;
          end else if (p_wrap) begin
            p_d  = '0;
            en_d = tick_en;
          end else begin
            p_d = p_q + 1'b1;
          end
        end

        S_PAUSE: begin
          if (bus.start) state_d = S_RUN;
        end

        S_ALARM: begin
          if (bus.start) begin
            state_d = S_IDLE;
            p_d     = '0;
            a_d     = '0;
          end else if (p_wrap) begin
            p_d = '0;
            if (a_q == A_LAST) begin
              state_d = S_IDLE;
              a_d     = '0;
            end else begin
              a_d = a_q + 1'b1;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset also clears the external counters.
  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (RESET) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      a_q       <= '0;
      sel_q     <= '0;
      en_q      <= '0;
      cnt_clr_q <= 1'b1;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      a_q       <= a_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
    end
  end

  assign bus.en      = en_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.sel     = sel_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl with two digits, a 4-cycle tick
// and a 2-tick alarm. Models the external BCD digit counters and predicts
// countdown behaviour from the loaded value with plain arithmetic.
module tb_bcd_timer_ctrl;

  localparam int DIGITS      = 2;
  localparam int PRESCALE    = 4;
  localparam int ALARM_TICKS = 2;

  logic CLOCK = 1'b0;
  logic RESET;

  int vectors     = 0;
  int miscompares = 0;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_ctrl #(
    .DIGITS      (DIGITS),
    .PRESCALE    (PRESCALE),
    .ALARM_TICKS (ALARM_TICKS)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // External BCD down-counter digits driven by the sequencer.
  int digit [DIGITS] = '{default: 0};

  always @(posedge CLOCK) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.cnt_clr === 1'b1)      digit[i] <= 0;
      else if (bus.en[i] === 1'b1)   digit[i] <= (digit[i] == 0) ? 9 : digit[i] - 1;
    end
  end

  assign bus.digz = {digit[1] == 0, digit[0] == 0};

  // Packed view of all outputs: {en[1:0], cnt_clr, sel[1:0], running, alarm}.
  function automatic logic [6:0] obs();
    return {bus.en, bus.cnt_clr, bus.sel, bus.running, bus.alarm};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic pulse(input logic c, input logic s, input logic m, input logic a);
    bus.clear = c;
    bus.start = s;
    bus.mode  = m;
    bus.adj   = a;
    step();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.adj   = 1'b0;
  endtask

  // Clear, then dial value v (0..99) in through set mode; ends in IDLE.
  task automatic load_value(input int v);
    int k0, k1;
    k0 = (10 - v % 10) % 10;
    k1 = (10 - v / 10) % 10;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (k0) begin pulse(1'b0, 1'b0, 1'b0, 1'b1); step(); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (k1) begin pulse(1'b0, 1'b0, 1'b0, 1'b1); step(); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.adj   = 1'b0;
    bus.clear = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    vectors++;
    if (obs() !== 7'b0010000) begin
      miscompares++;
      $display("FAIL reset_first: got %b expected %b", obs(), 7'b0010000);
    end
    step();
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL reset_settle: got %b expected %b", obs(), 7'b0000000);
    end

    // Reset held for 3 cycles in the middle of a countdown.
    load_value(5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) step();
    vectors++;
    if (bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prerun: got running=%b expected 1", bus.running);
    end
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    vectors++;
    if (obs() !== 7'b0010000) begin
      miscompares++;
      $display("FAIL reset_midrun_clr: got %b expected %b", obs(), 7'b0010000);
    end
    step();
    for (int c = 0; c < 2 * PRESCALE; c++) begin
      vectors++;
      if (obs() !== 7'b0000000) begin
        miscompares++;
        $display("FAIL reset_midrun_idle c=%0d: got %b expected %b", c, obs(), 7'b0000000);
      end
      step();
    end
    vectors++;
    if (bus.digz !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_counters: got digz=%b expected 11", bus.digz);
    end
  endtask

  task automatic test_set_mode();
    int v;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL set_enter: got %b expected %b", obs(), 7'b0000000);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs() !== 7'b0100000) begin
      miscompares++;
      $display("FAIL set_adj0: got %b expected %b", obs(), 7'b0100000);
    end
    step();
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL set_adj0_single: got %b expected %b", obs(), 7'b0000000);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs() !== 7'b0000100) begin
      miscompares++;
      $display("FAIL set_mode_beats_adj: got %b expected %b", obs(), 7'b0000100);
    end
    step();
    vectors++;
    if (obs() !== 7'b0000100) begin
      miscompares++;
      $display("FAIL set_adj_dropped: got %b expected %b", obs(), 7'b0000100);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs() !== 7'b1000100) begin
      miscompares++;
      $display("FAIL set_adj1: got %b expected %b", obs(), 7'b1000100);
    end
    step();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== 7'b0000100) begin
      miscompares++;
      $display("FAIL set_start_ignored: got %b expected %b", obs(), 7'b0000100);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL set_exit: got %b expected %b", obs(), 7'b0000000);
    end
    vectors++;
    if (digit[0] != 9 || digit[1] != 9) begin
      miscompares++;
      $display("FAIL set_wrap: got %0d%0d expected 99", digit[1], digit[0]);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL idle_adj_ignored: got %b expected %b", obs(), 7'b0000000);
    end
    v = $urandom_range(1, 99);
    load_value(v);
    step();
    vectors++;
    if (digit[0] != v % 10 || digit[1] != v / 10) begin
      miscompares++;
      $display("FAIL set_load: got %0d%0d expected %0d", digit[1], digit[0], v);
    end
  endtask

  // Load n, start, and check every output on every cycle through the alarm
  // and back to idle. With noise, stray MODE/ADJ pulses are thrown in.
  task automatic test_countdown(input int n, input bit noise);
    logic [6:0] exp;
    int v, last, alarm_on;
    load_value(n);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    alarm_on = PRESCALE * n + 2;
    last     = alarm_on + ALARM_TICKS * PRESCALE + 1;
    for (int c = 0; c <= last; c++) begin
      exp = '0;
      if (c > 0 && c % PRESCALE == 0 && c / PRESCALE <= n) begin
        v        = n - c / PRESCALE + 1;  // displayed value before this tick
        exp[6:5] = {v % 10 == 0, 1'b1};
      end
      exp[1] = (c < alarm_on);
      exp[0] = (c >= alarm_on && c < alarm_on + ALARM_TICKS * PRESCALE);
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL countdown n=%0d c=%0d: got %b expected %b", n, c, obs(), exp);
      end
      if (noise && c < alarm_on + ALARM_TICKS * PRESCALE - 2) begin
        bus.mode = ($urandom % 3 == 0);
        bus.adj  = ($urandom % 3 == 0);
      end
      step();
      bus.mode = 1'b0;
      bus.adj  = 1'b0;
    end
  endtask

  task automatic test_pause_resume();
    load_value(20);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step();
    vectors++;
    if (bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_prerun: got running=%b expected 1", bus.running);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (obs() !== 7'b0000000) begin
        miscompares++;
        $display("FAIL pause_hold i=%0d: got %b expected %b", i, obs(), 7'b0000000);
      end
      step();
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 6; c++) begin
      logic [6:0] exp;
      exp = (c == 2 || c == 6) ? 7'b0100010 : 7'b0000010;
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL resume c=%0d: got %b expected %b", c, obs(), exp);
      end
      step();
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2 * PRESCALE; c++) begin
      vectors++;
      if (obs() !== 7'b0000000) begin
        miscompares++;
        $display("FAIL zero_start c=%0d: got %b expected %b", c, obs(), 7'b0000000);
      end
      step();
    end

    load_value(5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== 7'b0010000) begin
      miscompares++;
      $display("FAIL clear_beats_start: got %b expected %b", obs(), 7'b0010000);
    end
    step();
    vectors++;
    if (obs() !== 7'b0000000 || bus.digz !== 2'b11) begin
      miscompares++;
      $display("FAIL clear_single: got %b digz=%b expected %b digz=11", obs(), bus.digz, 7'b0000000);
    end
    // From PAUSE this START would resume; from IDLE with zero digits it is ignored.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL clear_not_pause: got %b expected %b", obs(), 7'b0000000);
    end

    load_value(3);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs() !== 7'b0000010) begin
      miscompares++;
      $display("FAIL start_beats_mode: got %b expected %b", obs(), 7'b0000010);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_alarm_ack();
    int n;
    n = $urandom_range(1, 9);
    load_value(n);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (PRESCALE * n + 2 + 3) step();
    vectors++;
    if (obs() !== 7'b0000001) begin
      miscompares++;
      $display("FAIL alarm_before_ack n=%0d: got %b expected %b", n, obs(), 7'b0000001);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL alarm_ack n=%0d: got %b expected %b", n, obs(), 7'b0000000);
    end
    step();
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++;
      $display("FAIL alarm_ack_idle n=%0d: got %b expected %b", n, obs(), 7'b0000000);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      test_countdown($urandom_range(1, 99), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_set_mode();
    test_countdown(2, 1'b0);
    test_countdown(10, 1'b0);
    test_pause_resume();
    test_priority();
    test_alarm_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
